input_buffer_rc: RTL and testbench
==================================

Name: input_buffer_rc

Overview:
- Per-input-port flit FIFO with lookahead route computation.
- Sits directly upstream of the unicast arbiter; one instance per port (L, N, E, S, W).
- Accepts flits from the link or local core, computes the 5-bit output-port label at write time, and stores label and flit together.
- Presents the head flit and its label to the arbiter and pops on the arbiter's ready.

Parameters:
DEPTH, 4, FIFO entries (power of two)
WIDTH, 2, pointer width, log2(DEPTH)
DATASIZE, 30, flit width in bits
router_ID, 6, this router's node ID
MESH_X, 4, mesh columns; cur_x = router_ID % MESH_X, cur_y = router_ID / MESH_X
IDW, 4, destination-ID field width; dest ID = in_data[DATASIZE-1 -: IDW]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream flit valid
in_data  in  DATASIZE  upstream flit
full  out  1  buffer full, to upstream (upstream must not push while 1)
label  out  5  head flit output-port request {W,N,E,S,L}; 5'b0 when empty
data_out  out  DATASIZE  head flit; 0 when empty
ready  in  1  arbiter grant-and-not-full for this port; pops head
drop_cnt  out  8  dropped-push counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high. All state updates occur on posedge clk.
- Reset: wr_ptr = rd_ptr = 0, count = 0, full = 0, label = 0, data_out = 0, drop_cnt = 0. Reset has priority over push and pop and discards any stored flits mid-operation.
- Storage: DEPTH entries of {label[4:0], flit[DATASIZE-1:0]}. count is WIDTH+1 bits; pointers wrap modulo DEPTH.
- Route computation (combinational on in_data at push), XY dimension order:
  - dst_x = dest % MESH_X, dst_y = dest / MESH_X.
  - dst_x > cur_x -> E (5'b00100); dst_x < cur_x -> W (5'b10000).
  - Otherwise dst_y > cur_y -> N (5'b01000); dst_y < cur_y -> S (5'b00010).
  - Otherwise L (5'b00001).
  - The label is always one-hot.
- Push = in_valid & (count < DEPTH). Pop = ready & (count != 0).
- Outputs are driven combinationally from the head entry. A flit pushed at edge t appears on label/data_out after edge t, i.e. one-cycle latency to head.
- full = (count == DEPTH), derived from registered count.
- Simultaneous push and pop:
  - Not full: both happen; count unchanged.
  - When full: the push is refused (full was 1) and the pop proceeds. No same-cycle bypass of a full buffer.
- Pop while empty: ignored; pointers and count unchanged.
- Push while full: flit discarded, state unchanged; drop_cnt increments if enabled.
- Empty with in_valid: the flit is not forwarded in the same cycle (no bypass); label stays 0 until the next edge.
- Labels hold stable while the head is not popped, so the arbiter sees a constant request.

Optional Feature:
- Macro: INPUT_BUFFER_DROP_CNT_EN.
- Defined: drop_cnt is an 8-bit counter, incremented on every cycle with in_valid & full. It saturates at 8'hFF and clears only on rst.
- Undefined: drop_cnt is tied to 8'h00 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Routing (router_ID=6, MESH_X=4, so cur=(2,1)): push dest 7, 4, 10, 2, 6 with ready=0 -> after each push the head label stays 5'b00100 (first flit). Then pop one flit per cycle -> labels in order 00100, 10000, 01000 and, after a refill, 00010, 00001; data_out matches the pushed flits in order.
- Fill and full: push 4 flits (ready=0) -> full=1 after the 4th edge. A 5th push of 30'h1234 is refused; drop_cnt=1 with the macro, 0 without. Pop all 4 -> original order, then label=0, data_out=0, full=0.
- Simultaneous push and pop at count=2 -> count stays 2, FIFO order preserved. At count=4 with push and pop -> count becomes 3, pushed flit dropped.
- Empty pop: ready=1 for 3 cycles on an empty buffer -> label=0, no pointer movement. A following push of dest 6 -> label=00001 one cycle later.
- Reset mid-operation: 3 flits stored, assert rst for one cycle while in_valid=1 and ready=1 -> next cycle count=0, label=0, full=0, drop_cnt=0, incoming flit not stored.
- Wrap-around: 10 push/pop pairs across the pointer wrap -> data_out sequence equals the input sequence, no corruption.

Source files
------------

// File: rtl/input_buffer_rc.sv
// Per-port flit FIFO that computes the XY output-port label when a flit is written.
// Define INPUT_BUFFER_DROP_CNT_EN to build the saturating dropped-push counter; otherwise drop_cnt is 0.
module input_buffer_rc #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 2,
    parameter int DATASIZE  = 30,
    parameter int router_ID = 6,
    parameter int MESH_X    = 4,
    parameter int IDW       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATASIZE-1:0] in_data,
    output logic                full,
    output logic [4:0]          label,
    output logic [DATASIZE-1:0] data_out,
    input  logic                ready,
    output logic [7:0]          drop_cnt
);

    localparam int             CUR_X    = router_ID % MESH_X;
    localparam int             CUR_Y    = router_ID / MESH_X;
    localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

    // XY dimension order: resolve X first, then Y, else deliver locally.
    function automatic logic [4:0] route_label(input logic [IDW-1:0] dest);
        int dst_x;
        int dst_y;
        dst_x = int'(dest) % MESH_X;
        dst_y = int'(dest) / MESH_X;
        if (dst_x > CUR_X)      return 5'b00100;
        else if (dst_x < CUR_X) return 5'b10000;
        else if (dst_y > CUR_Y) return 5'b01000;
        else if (dst_y < CUR_Y) return 5'b00010;
        else                    return 5'b00001;
    endfunction

    logic [DATASIZE+4:0] r_mem [DEPTH];
    logic [WIDTH-1:0]    r_wr_ptr;
    logic [WIDTH-1:0]    r_rd_ptr;
    logic [WIDTH:0]      r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [4:0]          w_label;
    logic [DATASIZE+4:0] w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = ready & ~w_empty;
    assign w_label = route_label(in_data[DATASIZE-1 -: IDW]);
    assign w_head  = r_mem[r_rd_ptr];

    assign full     = w_full;
    assign label    = w_empty ? 5'b0 : w_head[DATASIZE+4:DATASIZE];
    assign data_out = w_empty ? '0 : w_head[DATASIZE-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wr_ptr] <= {w_label, in_data};
    end

`ifdef INPUT_BUFFER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_drop_cnt <= 8'h00;
        else if (in_valid && w_full && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'h01;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_input_buffer_rc.sv
// Bench for input_buffer_rc: vector table, directed corner sequences and random traffic
// against a queue-based reference model. Honors INPUT_BUFFER_DROP_CNT_EN for drop_cnt.
module tb_input_buffer_rc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [29:0] in_data;
    logic        full;
    logic [4:0]  label;
    logic [29:0] data_out;
    logic        ready;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    input_buffer_rc #(
        .DEPTH(4), .WIDTH(2), .DATASIZE(30), .router_ID(6), .MESH_X(4), .IDW(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .full(full),
        .label(label), .data_out(data_out), .ready(ready), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of {label, flit}, at most 4 deep.
    logic [34:0] mq[$];
    int          mdrop;

    function automatic logic [4:0] ref_label(input logic [29:0] d);
        int dest, dx, dy;
        dest = int'(d[29:26]);
        dx = dest % 4;
        dy = dest / 4;
        // this router sits at (2,1)
        if (dx > 2)      return 5'b00100;
        if (dx < 2)      return 5'b10000;
        if (dy > 1)      return 5'b01000;
        if (dy < 1)      return 5'b00010;
        return 5'b00001;
    endfunction

    function automatic logic [29:0] mk(input int dest, input int tag);
        logic [3:0] d4;
        d4 = 4'(dest);
        return {d4, 26'(tag)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [29:0] d, input bit rd);
        bit was_full, do_push, do_pop;
        rst = r; in_valid = v; in_data = d; ready = rd;
        if (r) begin
            mq.delete();
            mdrop = 0;
        end else begin
            was_full = (mq.size() == 4);
            do_push  = v && !was_full;
            do_pop   = rd && (mq.size() > 0);
`ifdef INPUT_BUFFER_DROP_CNT_EN
            if (v && was_full && mdrop < 255) mdrop++;
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({ref_label(d), d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [4:0]  el;
        logic [29:0] ed;
        el = (mq.size() > 0) ? mq[0][34:30] : 5'b0;
        ed = (mq.size() > 0) ? mq[0][29:0] : 30'b0;
        chk({tag, ".label"}, 32'(label), 32'(el));
        chk({tag, ".data"}, 32'(data_out), 32'(ed));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == 4));
        chk({tag, ".drop"}, 32'(drop_cnt), 32'(mdrop));
    endtask

    typedef struct {
        bit          r;
        bit          v;
        logic [29:0] d;
        bit          rd;
        logic [4:0]  el;
        logic [29:0] ed;
        bit          ef;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(input bit r, input bit v, input logic [29:0] d, input bit rd,
                                 input logic [4:0] el, input logic [29:0] ed, input bit ef);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.rd = rd; x.el = el; x.ed = ed; x.ef = ef;
        return x;
    endfunction

    initial begin
        logic [29:0] f [10];
        logic [29:0] w [11];
        logic [29:0] one_flit;
        logic [7:0]  exp_drop1;
`ifdef INPUT_BUFFER_DROP_CNT_EN
        exp_drop1 = 8'd1;
`else
        exp_drop1 = 8'd0;
`endif
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ready = 1'b0;
        mdrop = 0;

        // Routing table: dests 7,4,10,2,6 pushed with ready low, then popped.
        vecs[0]  = mkv(1, 0, 30'h0,     0, 5'b00000, 30'h0,     0);
        vecs[1]  = mkv(0, 1, mk(7, 1),  0, 5'b00100, mk(7, 1),  0);
        vecs[2]  = mkv(0, 1, mk(4, 2),  0, 5'b00100, mk(7, 1),  0);
        vecs[3]  = mkv(0, 1, mk(10, 3), 0, 5'b00100, mk(7, 1),  0);
        vecs[4]  = mkv(0, 1, mk(2, 4),  0, 5'b00100, mk(7, 1),  1);
        vecs[5]  = mkv(0, 1, mk(6, 5),  0, 5'b00100, mk(7, 1),  1);
        vecs[6]  = mkv(0, 0, 30'h0,     1, 5'b10000, mk(4, 2),  0);
        vecs[7]  = mkv(0, 0, 30'h0,     1, 5'b01000, mk(10, 3), 0);
        vecs[8]  = mkv(0, 0, 30'h0,     1, 5'b00010, mk(2, 4),  0);
        vecs[9]  = mkv(0, 0, 30'h0,     1, 5'b00000, 30'h0,     0);
        vecs[10] = mkv(0, 1, mk(6, 6),  0, 5'b00001, mk(6, 6),  0);
        vecs[11] = mkv(0, 0, 30'h0,     1, 5'b00000, 30'h0,     0);

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d.label", i), 32'(label), 32'(vecs[i].el));
            chk($sformatf("vec%0d.data", i), 32'(data_out), 32'(vecs[i].ed));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].ef));
        end

        // Fill, refused push, drain.
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            f[i] = mk(i * 3 + 1, 100 + i);
            cycle(0, 1, f[i], 0);
        end
        chk("fill.full", 32'(full), 32'd1);
        cycle(0, 1, 30'h1234, 0);
        chk("fill.full_after_drop", 32'(full), 32'd1);
        chk("fill.drop_cnt", 32'(drop_cnt), 32'(exp_drop1));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.data", i), 32'(data_out), 32'(f[i]));
            cycle(0, 0, '0, 1);
        end
        chk("drain.label", 32'(label), 32'd0);
        chk("drain.data", 32'(data_out), 32'd0);
        chk("drain.full", 32'(full), 32'd0);

        // Simultaneous push and pop at count 2, then at count 4.
        cycle(1, 0, '0, 0);
        cycle(0, 1, mk(1, 201), 0);
        cycle(0, 1, mk(8, 202), 0);
        cycle(0, 1, mk(14, 203), 1);
        chk("pp2.head", 32'(data_out), 32'(mk(8, 202)));
        cycle(0, 0, '0, 1);
        chk("pp2.next", 32'(data_out), 32'(mk(14, 203)));
        cycle(0, 0, '0, 1);
        chk("pp2.empty", 32'(label), 32'd0);
        for (int i = 0; i < 4; i++) begin
            f[i] = mk(i + 5, 300 + i);
            cycle(0, 1, f[i], 0);
        end
        cycle(0, 1, mk(3, 399), 1);
        chk("pp4.full", 32'(full), 32'd0);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("pp4.order%0d", i), 32'(data_out), 32'(f[i]));
            cycle(0, 0, '0, 1);
        end
        chk("pp4.dropped", 32'(label), 32'd0);
        check_model("pp4");

        // Pops on an empty buffer, then a local-destination push.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, 1);
            chk($sformatf("epop%0d.label", i), 32'(label), 32'd0);
        end
        one_flit = mk(6, 42);
        cycle(0, 1, one_flit, 0);
        chk("epop.local_label", 32'(label), 32'b00001);
        chk("epop.local_data", 32'(data_out), 32'(one_flit));

        // Reset while pushing and popping with flits stored.
        cycle(0, 1, mk(0, 50), 0);
        cycle(0, 1, mk(15, 51), 0);
        cycle(1, 1, mk(9, 52), 1);
        chk("rstmid.label", 32'(label), 32'd0);
        chk("rstmid.data", 32'(data_out), 32'd0);
        chk("rstmid.full", 32'(full), 32'd0);
        chk("rstmid.drop", 32'(drop_cnt), 32'd0);
        cycle(0, 0, '0, 0);
        chk("rstmid.not_stored", 32'(label), 32'd0);

        // Wrap-around: steady push/pop pairs across the pointer wrap.
        for (int i = 0; i < 11; i++) w[i] = mk(i, 500 + i);
        cycle(0, 1, w[0], 0);
        for (int i = 1; i < 11; i++) begin
            chk($sformatf("wrap%0d", i - 1), 32'(data_out), 32'(w[i - 1]));
            cycle(0, 1, w[i], 1);
        end
        chk("wrap.last", 32'(data_out), 32'(w[10]));

        // Random traffic against the reference model.
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                  30'($urandom()), ($urandom_range(0, 2) == 0) || (i > 300));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
